reflet_fpu_sequencer: RTL and testbench
=======================================

# reflet_fpu_sequencer

Command-side initiator for the Reflet FPU arithmetic unit. It accepts one FPU instruction at a time over a valid/ready handshake, reads the operands from a small float register file, and drives the arithmetic unit's `enable`/`opcode`/operand inputs. It holds them stable until `ready`, writes the result back, and reports completion, error and the result flag. It sits between the CPU's FPU instruction decoder and the arithmetic unit.

## Interface
- `float_size`, 32: float width in bits.
- `reg_count`, 8: number of float registers (power of two); `idx_w` = log2(`reg_count`).
- `timeout`, 255: maximum EXEC cycles before abort; 8-bit counter.

Ports, in the order name, direction, width, meaning:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-low.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: sequencer can accept.
- `cmd_opcode`, in, 6: FPU opcode (`OPP_*` from `reflet_fpu.vh`).
- `cmd_dst`, `cmd_src1`, `cmd_src2`, `cmd_src3`, in, `idx_w` each: register indices.
- `wr_en`, `wr_idx`, `wr_data`, in, 1 / `idx_w` / `float_size`: host register write.
- `rd_idx` (in, `idx_w`) and `rd_data` (out, `float_size`): combinational host read.
- `au_enable`, out, 1: to the arithmetic unit's `enable`.
- `au_opcode`, out, 6: to the arithmetic unit's `opcode`.
- `au_in1`, `au_in2`, `au_in3`, out, `float_size` each: operands.
- `au_ready`, in, 1: arithmetic unit done.
- `au_out`, in, `float_size`: result.
- `au_flag`, in, 1: result flag.
- `done`, out, 1: one-cycle completion pulse.
- `error`, out, 1: last command aborted; holds until the next accept.
- `flag`, out, 1: `au_flag` captured at the last successful writeback.

## Operation
- States: IDLE, EXEC, GAP.
- IDLE:
  - `cmd_ready`=1. A command is accepted when `cmd_valid & cmd_ready`.
  - On accept, latch the opcode, `dst`, and `regs[src1..3]` into operand registers. Reads see pre-write values when a host write hits the same index in the accept cycle.
  - Clear `error` and the timeout counter.
  - Legal opcodes are ADD, SUB, MUL, DIV, INV, FISQRT, CUBE, TESSERACT, TRIMULT, MULTADD. A legal opcode moves to EXEC.
  - An illegal opcode sets `error`=1 and moves to GAP. The arithmetic unit is never enabled.
- EXEC:
  - `au_enable`=1. `au_opcode` and `au_in*` come from the latches and are stable throughout.
  - If `au_ready` is high in a cycle, write `au_out` to `regs[dst]`, capture `flag`, and move to GAP.
  - Otherwise the counter increments. When the counter reaches `timeout`, set `error`=1, do no writeback, and move to GAP.
- GAP:
  - `au_enable`=0 for exactly one cycle. This guarantees the multi-cycle units restart on the next op.
  - `done`=1, then return to IDLE.
- Register file:
  - Host writes are accepted in any state.
  - If a host write and an AU writeback target the same index in the same cycle, the AU writeback wins.
- Outputs that are don't-care outside EXEC: `au_opcode` and `au_in*` hold their last latched values.

## Timing
- Reset values:
  - state IDLE; `cmd_ready`=1; `au_enable`=0; `done`=0; `error`=0; `flag`=0.
  - All registers and operand latches 0; `au_opcode`=0.
- Reset asserted mid-EXEC: IDLE on the next edge, `au_enable`=0 from that edge, no writeback, no `done`.
- Latency (accept at edge 0):
  - EXEC starts at cycle 1.
  - If `au_ready` is first seen in EXEC cycle k, writeback happens at edge k+1 and `done` is high during cycle k+1.
  - `cmd_ready` returns in cycle k+2.
  - ADD/SUB (ready combinational with enable): k=1. `done` is in cycle 2, and the next accept is possible at cycle 3.
  - Illegal opcode: `done` in cycle 1.
  - Timeout: `done` in cycle `timeout`+1.
- `au_ready` is sampled only in EXEC. `au_ready` while `au_enable`=0 is ignored.
- Back-to-back commands are never overlapped; throughput is one command per k+2 cycles.

## Structure
- Add the sequencer state encodings (IDLE/EXEC/GAP) and the opcode-legality macro to `reflet_fpu.vh`, next to the existing `OPP_*` defines.
- Sub-module `reflet_fpu_regfile`:
  - Parameters `float_size` and `reg_count`.
  - Three combinational read ports for operands and one for the host.
  - Two write ports with a fixed priority (AU over host).
- FSM, latches and counter live in `reflet_fpu_sequencer`.

## Test plan
- Basic add:
  - Host writes r1=0x3FC00000 (1.5) and r2=0x40000000 (2.0), then issues ADD dst=r3.
  - Required: `done` in cycle 2, r3=0x40600000 (3.5), `cmd_ready` high again in cycle 3.
- Multi-cycle AU with stable outputs:
  - MUL r1,r2→r4 against a model asserting `au_ready` 5 cycles after enable.
  - Required: `au_in*`/`au_opcode` stable through EXEC, r4=0x40400000, one-cycle `au_enable`=0 GAP before the next command.
- Timeout abort:
  - `au_ready` tied low, `timeout`=16.
  - Required: `error`=1 and `done` in cycle 17, r-dst unchanged, `error` cleared on the next accept.
- Illegal opcode:
  - Issue opcode 6'h3F.
  - Required: `au_enable` never rises, `done`+`error` in cycle 1.
- Writeback collision:
  - Host writes r3=0xDEADBEEF in the same cycle as the ADD writeback to r3.
  - Required: r3=0x40600000.
- Reset mid-operation:
  - Drop `reset` during EXEC of a 5-cycle MUL.
  - Required: next cycle IDLE, `au_enable`=0, all registers 0, no `done`.

Source files
------------

// File: rtl/reflet_fpu_sequencer_pkg.sv
// Shared types and opcode constants for the Reflet FPU command sequencer.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package reflet_fpu_sequencer_pkg;

    // Sequencer states: wait for a command, drive the AU, one-cycle idle gap.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_GAP  = 2'd2
    } seq_state_t;

    localparam logic [5:0] OPP_ADD       = 6'h00;
    localparam logic [5:0] OPP_SUB       = 6'h01;
    localparam logic [5:0] OPP_MUL       = 6'h02;
    localparam logic [5:0] OPP_DIV       = 6'h03;
    localparam logic [5:0] OPP_INV       = 6'h04;
    localparam logic [5:0] OPP_FISQRT    = 6'h05;
    localparam logic [5:0] OPP_CUBE      = 6'h06;
    localparam logic [5:0] OPP_TESSERACT = 6'h07;
    localparam logic [5:0] OPP_TRIMULT   = 6'h08;
    localparam logic [5:0] OPP_MULTADD   = 6'h09;

    // True for opcodes the arithmetic unit implements; anything else aborts.
    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OPP_ADD, OPP_SUB, OPP_MUL, OPP_DIV, OPP_INV,
            OPP_FISQRT, OPP_CUBE, OPP_TESSERACT, OPP_TRIMULT,
            OPP_MULTADD: op_legal = 1'b1;
            default:     op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/reflet_fpu_regfile.sv
// Float register file: three operand read ports, one host read port, AU + host writes.
// Latency: reads combinational, writes land on the next clock edge.
// Backpressure: none; an AU write wins over a host write to the same index.
module reflet_fpu_regfile #(
    parameter int float_size = 32,
    parameter int reg_count  = 8,
    localparam int idx_w     = $clog2(reg_count)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [idx_w-1:0]      rd1_idx,
    input  logic [idx_w-1:0]      rd2_idx,
    input  logic [idx_w-1:0]      rd3_idx,
    output logic [float_size-1:0] rd1_data,
    output logic [float_size-1:0] rd2_data,
    output logic [float_size-1:0] rd3_data,
    input  logic [idx_w-1:0]      host_rd_idx,
    output logic [float_size-1:0] host_rd_data,
    input  logic                  au_wr_en,
    input  logic [idx_w-1:0]      au_wr_idx,
    input  logic [float_size-1:0] au_wr_data,
    input  logic                  host_wr_en,
    input  logic [idx_w-1:0]      host_wr_idx,
    input  logic [float_size-1:0] host_wr_data
);

    logic [float_size-1:0] regs [reg_count];

    assign rd1_data     = regs[rd1_idx];
    assign rd2_data     = regs[rd2_idx];
    assign rd3_data     = regs[rd3_idx];
    assign host_rd_data = regs[host_rd_idx];

    // Clear on reset; otherwise apply both writers, AU taking the colliding index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < reg_count; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (host_wr_en && !(au_wr_en && (au_wr_idx == host_wr_idx))) begin
                regs[host_wr_idx] <= host_wr_data;
            end
            if (au_wr_en) begin
                regs[au_wr_idx] <= au_wr_data;
            end
        end
    end

endmodule

// File: rtl/reflet_fpu_sequencer.sv
// Issues one FPU command at a time to the arithmetic unit and writes the result back.
// Latency: accept -> EXEC next cycle; done one cycle after au_ready; ready again one later.
// Backpressure: cmd_ready low from accept until the GAP cycle has passed.
module reflet_fpu_sequencer
    import reflet_fpu_sequencer_pkg::*;
#(
    parameter int float_size = 32,
    parameter int reg_count  = 8,
    parameter int timeout    = 255,
    localparam int idx_w     = $clog2(reg_count)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [5:0]            cmd_opcode,
    input  logic [idx_w-1:0]      cmd_dst,
    input  logic [idx_w-1:0]      cmd_src1,
    input  logic [idx_w-1:0]      cmd_src2,
    input  logic [idx_w-1:0]      cmd_src3,
    input  logic                  wr_en,
    input  logic [idx_w-1:0]      wr_idx,
    input  logic [float_size-1:0] wr_data,
    input  logic [idx_w-1:0]      rd_idx,
    output logic [float_size-1:0] rd_data,
    output logic                  au_enable,
    output logic [5:0]            au_opcode,
    output logic [float_size-1:0] au_in1,
    output logic [float_size-1:0] au_in2,
    output logic [float_size-1:0] au_in3,
    input  logic                  au_ready,
    input  logic [float_size-1:0] au_out,
    input  logic                  au_flag,
    output logic                  done,
    output logic                  error,
    output logic                  flag
);

    seq_state_t            state;
    logic [7:0]            cnt;
    logic [7:0]            cnt_inc;
    logic [idx_w-1:0]      dst_q;
    logic [float_size-1:0] op1_data;
    logic [float_size-1:0] op2_data;
    logic [float_size-1:0] op3_data;
    logic                  wb_en;

    assign cnt_inc = cnt + 8'd1;
    // au_ready only counts while the AU is actually being driven.
    assign wb_en   = (state == S_EXEC) && au_ready;

    reflet_fpu_regfile #(
        .float_size (float_size),
        .reg_count  (reg_count)
    ) u_regfile (
        .clk          (clk),
        .reset        (reset),
        .rd1_idx      (cmd_src1),
        .rd2_idx      (cmd_src2),
        .rd3_idx      (cmd_src3),
        .rd1_data     (op1_data),
        .rd2_data     (op2_data),
        .rd3_data     (op3_data),
        .host_rd_idx  (rd_idx),
        .host_rd_data (rd_data),
        .au_wr_en     (wb_en),
        .au_wr_idx    (dst_q),
        .au_wr_data   (au_out),
        .host_wr_en   (wr_en),
        .host_wr_idx  (wr_idx),
        .host_wr_data (wr_data)
    );

    // Command FSM with registered handshake, AU drive and status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            au_enable <= 1'b0;
            au_opcode <= '0;
            au_in1    <= '0;
            au_in2    <= '0;
            au_in3    <= '0;
            dst_q     <= '0;
            cnt       <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            flag      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        au_opcode <= cmd_opcode;
                        dst_q     <= cmd_dst;
                        au_in1    <= op1_data;
                        au_in2    <= op2_data;
                        au_in3    <= op3_data;
                        cnt       <= '0;
                        cmd_ready <= 1'b0;
                        if (op_legal(cmd_opcode)) begin
                            error     <= 1'b0;
                            au_enable <= 1'b1;
                            state     <= S_EXEC;
                        end else begin
                            // Never touch the AU with an opcode it does not know.
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= S_GAP;
                        end
                    end
                end
                S_EXEC: begin
                    if (au_ready) begin
                        flag      <= au_flag;
                        au_enable <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_GAP;
                    end else if (cnt_inc == 8'(timeout)) begin
                        error     <= 1'b1;
                        au_enable <= 1'b0;
                        done      <= 1'b1;
                        state     <= S_GAP;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                S_GAP: begin
                    // One enable-low cycle lets multi-cycle units restart cleanly.
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: begin
                    au_enable <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_fpu_sequencer.sv
// Directed bench for reflet_fpu_sequencer with a small arithmetic-unit model.
// Latency: AU model answers immediately, after 5 enabled cycles, or never.
// Backpressure: commands issued only when cmd_ready is seen high.
module tb_reflet_fpu_sequencer;
    import reflet_fpu_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [5:0]  cmd_opcode;
    logic [2:0]  cmd_dst, cmd_src1, cmd_src2, cmd_src3;
    logic        wr_en;
    logic [2:0]  wr_idx;
    logic [31:0] wr_data;
    logic [2:0]  rd_idx;
    logic [31:0] rd_data;
    logic        au_enable;
    logic [5:0]  au_opcode;
    logic [31:0] au_in1, au_in2, au_in3;
    logic        au_ready;
    logic [31:0] au_out;
    logic        au_flag;
    logic        done, error, flag;

    int total = 0;
    int bad   = 0;
    int au_mode = 0;
    int en_cnt  = 0;
    logic [31:0] shadow [8];

    always #5 clk = ~clk;

    reflet_fpu_sequencer #(
        .float_size (32),
        .reg_count  (8),
        .timeout    (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_dst    (cmd_dst),
        .cmd_src1   (cmd_src1),
        .cmd_src2   (cmd_src2),
        .cmd_src3   (cmd_src3),
        .wr_en      (wr_en),
        .wr_idx     (wr_idx),
        .wr_data    (wr_data),
        .rd_idx     (rd_idx),
        .rd_data    (rd_data),
        .au_enable  (au_enable),
        .au_opcode  (au_opcode),
        .au_in1     (au_in1),
        .au_in2     (au_in2),
        .au_in3     (au_in3),
        .au_ready   (au_ready),
        .au_out     (au_out),
        .au_flag    (au_flag),
        .done       (done),
        .error      (error),
        .flag       (flag)
    );

    // AU model: results only for the operand pairs the bench uses.
    function automatic logic [31:0] au_model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op == OPP_ADD && a == 32'h3FC00000 && b == 32'h40000000) return 32'h40600000;
        if (op == OPP_SUB && a == 32'h40000000 && b == 32'h3FC00000) return 32'h3F000000;
        if (op == OPP_MUL && a == 32'h3FC00000 && b == 32'h40000000) return 32'h40400000;
        return 32'hBAD0BAD0;
    endfunction

    always @(posedge clk) en_cnt <= au_enable ? en_cnt + 1 : 0;

    // Mode 0 keeps ready high permanently (must be ignored outside EXEC).
    always_comb begin
        au_ready = 1'b0;
        if (au_mode == 0) au_ready = 1'b1;
        else if (au_mode == 1) au_ready = au_enable && (en_cnt == 5);
        au_out  = au_model(au_opcode, au_in1, au_in2);
        au_flag = (au_opcode == OPP_MUL);
    end

    typedef struct {
        logic [5:0]  op;
        logic [2:0]  dst;
        logic [2:0]  s1;
        logic [2:0]  s2;
        int          mode;
        int          done_cyc;
        logic [31:0] res;
        logic        err;
        logic        flg;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic host_write(input logic [2:0] idx, input logic [31:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = idx; wr_data = data;
        @(posedge clk);
        #1 wr_en = 1'b0;
        shadow[idx] = data;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        check("cmd_ready_wait", cmd_ready, 1'b1);
    endtask

    task automatic issue(input logic [5:0] op, input logic [2:0] dst, input logic [2:0] s1, input logic [2:0] s2);
        cmd_opcode = op; cmd_dst = dst; cmd_src1 = s1; cmd_src2 = s2; cmd_src3 = 3'd0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [2:0] idx, input logic [31:0] exp);
        rd_idx = idx;
        #1 check(name, rd_data, exp);
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int          done_cyc;
        logic        en_seen;
        logic [31:0] exp_dst;
        wait_ready();
        au_mode = v.mode;
        issue(v.op, v.dst, v.s1, v.s2);
        done_cyc = 0;
        en_seen  = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) check($sformatf("v%0d_error_at_accept", n), error, (v.done_cyc == 1) ? v.err : 1'b0);
            if (au_enable) begin
                en_seen = 1'b1;
                check($sformatf("v%0d_au_opcode_stable", n), au_opcode, v.op);
                check($sformatf("v%0d_au_in1_stable", n), au_in1, shadow[v.s1]);
                check($sformatf("v%0d_au_in2_stable", n), au_in2, shadow[v.s2]);
                check($sformatf("v%0d_au_in3_stable", n), au_in3, shadow[0]);
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        check($sformatf("v%0d_done_cycle", n), done_cyc, v.done_cyc);
        check($sformatf("v%0d_gap_enable_low", n), au_enable, 1'b0);
        check($sformatf("v%0d_error", n), error, v.err);
        check($sformatf("v%0d_au_enable_seen", n), en_seen, (v.done_cyc != 1));
        @(negedge clk);
        check($sformatf("v%0d_cmd_ready_after_gap", n), cmd_ready, 1'b1);
        check($sformatf("v%0d_done_one_cycle", n), done, 1'b0);
        exp_dst = v.err ? shadow[v.dst] : v.res;
        shadow[v.dst] = exp_dst;
        read_check($sformatf("v%0d_dst_value", n), v.dst, exp_dst);
        check($sformatf("v%0d_flag", n), flag, v.flg);
    endtask

    initial begin
        int seen_done;
        for (int i = 0; i < 8; i++) shadow[i] = 32'h0;
        vecs[0] = '{OPP_ADD, 3'd3, 3'd1, 3'd2, 0, 2,  32'h40600000, 1'b0, 1'b0};
        vecs[1] = '{OPP_MUL, 3'd4, 3'd1, 3'd2, 1, 7,  32'h40400000, 1'b0, 1'b1};
        vecs[2] = '{OPP_SUB, 3'd5, 3'd2, 3'd1, 0, 2,  32'h3F000000, 1'b0, 1'b0};
        vecs[3] = '{6'h3F,   3'd6, 3'd1, 3'd2, 0, 1,  32'h00000000, 1'b1, 1'b0};
        vecs[4] = '{OPP_MUL, 3'd7, 3'd1, 3'd2, 2, 17, 32'h00000000, 1'b1, 1'b0};
        vecs[5] = '{OPP_MUL, 3'd7, 3'd1, 3'd2, 1, 7,  32'h40400000, 1'b0, 1'b1};

        reset = 1'b0; cmd_valid = 1'b0; cmd_opcode = '0;
        cmd_dst = '0; cmd_src1 = '0; cmd_src2 = '0; cmd_src3 = '0;
        wr_en = 1'b0; wr_idx = '0; wr_data = '0; rd_idx = '0;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_au_enable", au_enable, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_flag", flag, 1'b0);
        check("rst_au_opcode", au_opcode, 6'h00);
        check("rst_au_in1", au_in1, 32'h0);
        read_check("rst_reg0", 3'd0, 32'h0);
        reset = 1'b1;

        host_write(3'd1, 32'h3FC00000);
        host_write(3'd2, 32'h40000000);
        read_check("host_write_r1", 3'd1, 32'h3FC00000);

        for (int n = 0; n < 6; n++) run_vec(n, vecs[n]);

        // Host write to a source in the accept cycle: operand latch sees the old value.
        wait_ready();
        au_mode = 0;
        wr_en = 1'b1; wr_idx = 3'd1; wr_data = 32'h11111111;
        issue(OPP_ADD, 3'd5, 3'd1, 3'd2);
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        read_check("prewrite_operand_result", 3'd5, 32'h40600000);
        read_check("prewrite_host_landed", 3'd1, 32'h11111111);
        host_write(3'd1, 32'h3FC00000);

        // Host write and AU writeback collide on r3: AU must win.
        host_write(3'd3, 32'h0);
        wait_ready();
        issue(OPP_ADD, 3'd3, 3'd1, 3'd2);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = 3'd3; wr_data = 32'hDEADBEEF;
        @(posedge clk);
        #1 wr_en = 1'b0;
        @(negedge clk);
        check("collide_done_cycle2", done, 1'b1);
        read_check("collide_r3", 3'd3, 32'h40600000);

        // Reset dropped during EXEC of a 5-cycle MUL.
        wait_ready();
        au_mode = 1;
        issue(OPP_MUL, 3'd4, 3'd1, 3'd2);
        repeat (3) @(negedge clk);
        check("mid_exec_enable", au_enable, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_enable", au_enable, 1'b0);
        check("rst_mid_ready", cmd_ready, 1'b1);
        check("rst_mid_done", done, 1'b0);
        reset = 1'b1;
        for (int i = 0; i < 8; i++) read_check($sformatf("rst_mid_reg%0d", i), 3'(i), 32'h0);
        seen_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || au_enable) seen_done++;
        end
        check("rst_mid_quiet_after", seen_done, 0);
        check("rst_mid_flag", flag, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
